// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one main-memory port between I-cache refill
// and D-cache refill/write-back, one transaction outstanding at a time.
module cache_mem_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int D_PRIORITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_d,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state;
    logic       owner_d;
    logic       last_d;
    logic       i_req;
    logic       d_req;
    logic       pick_d;
    logic       other_req;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

    // last_d=0 after reset, so round-robin hands D the first tie
    always_comb begin
        pick_d = d_req &&
                 (!i_req || (D_PRIORITY != 0) || !last_d);
    end

    always_comb begin
        other_req = 1'b0;
        unique case (1'b1)
            (state == GNT_I): other_req = d_req;
            (state == GNT_D): other_req = i_req;
            (state == DONE):  other_req = owner_d ? i_req : d_req;
            default:          other_req = 1'b0;
        endcase
    end

    assign grant_d = (state == GNT_D) ||
                     ((state == DONE) && owner_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner_d      <= 1'b0;
            last_d       <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_mem_rdata  <= '0;
            d_mem_rdata  <= '0;
            i_mem_ready  <= 1'b0;
            d_mem_ready  <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            i_mem_ready <= 1'b0;
            d_mem_ready <= 1'b0;
            if (other_req && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
            unique case (1'b1)
                (state == IDLE): begin
                    if (i_req || d_req) begin
                        owner_d <= pick_d;
                        if (pick_d) begin
                            mem_addr  <= d_mem_addr;
                            mem_wdata <= d_mem_wdata;
                            mem_write <= d_mem_write;
                            mem_read  <= !d_mem_write;
                            state     <= GNT_D;
                        end else begin
                            mem_addr  <= i_mem_addr;
                            mem_write <= 1'b0;
                            mem_read  <= 1'b1;
                            state     <= GNT_I;
                        end
                    end
                end
                (state == GNT_I),
                (state == GNT_D): begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        last_d    <= owner_d;
                        if (owner_d) begin
                            d_mem_ready <= 1'b1;
                            d_mem_rdata <= mem_rdata;
                        end else begin
                            i_mem_ready <= 1'b1;
                            i_mem_rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: randomized bench for cache_mem_arbiter with a
// latency-programmable memory responder and a transaction-level model.
module tb_cache_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_mem_read, d_mem_read, d_mem_write;
    logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
    logic [DW-1:0] d_mem_wdata, i_mem_rdata, d_mem_rdata;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          i_mem_ready, d_mem_ready, mem_ready;
    logic          mem_read, mem_write, grant_d;
    logic [15:0]   conflict_cnt;

    logic          p_i_read, p_d_read, p_d_write;
    logic [AW-1:0] p_i_addr, p_d_addr, p_mem_addr;
    logic [DW-1:0] p_d_wdata, p_i_rdata, p_d_rdata;
    logic [DW-1:0] p_mem_wdata, p_mem_rdata;
    logic          p_i_ready, p_d_ready, p_mem_ready;
    logic          p_mem_read, p_mem_write, p_grant_d;
    logic [3:0]    p_cnt;

    cache_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
        .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_d(grant_d), .conflict_cnt(conflict_cnt)
    );

    cache_mem_arbiter #(.D_PRIORITY(1), .CNT_W(4)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(p_i_read), .i_mem_addr(p_i_addr),
        .i_mem_rdata(p_i_rdata), .i_mem_ready(p_i_ready),
        .d_mem_read(p_d_read), .d_mem_write(p_d_write),
        .d_mem_addr(p_d_addr), .d_mem_wdata(p_d_wdata),
        .d_mem_rdata(p_d_rdata), .d_mem_ready(p_d_ready),
        .mem_read(p_mem_read), .mem_write(p_mem_write),
        .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
        .mem_rdata(p_mem_rdata), .mem_ready(p_mem_ready),
        .grant_d(p_grant_d), .conflict_cnt(p_cnt)
    );

    int n_checks = 0;
    int n_fail = 0;
    int lat_a = 0, wait_a = 0, lat_b = 0, wait_b = 0;
    bit auto_a = 1'b1, auto_b = 1'b1;
    logic [DW-1:0] rdata_a, rdata_b;

    // One clock; memory responders update on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (auto_a) begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                wait_a = 0;
            end else if (mem_read || mem_write) begin
                if (wait_a == lat_a) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata_a;
                end else begin
                    wait_a++;
                end
            end
        end
        if (auto_b) begin
            if (p_mem_ready) begin
                p_mem_ready = 1'b0;
                wait_b = 0;
            end else if (p_mem_read || p_mem_write) begin
                if (wait_b == lat_b) begin
                    p_mem_ready = 1'b1;
                    p_mem_rdata = rdata_b;
                end else begin
                    wait_b++;
                end
            end
        end
    endtask

    // Run until a ready pulse; the served requester then drops its request.
    task automatic serve(input int budget, output int n,
                         output bit gi, output bit gd);
        gi = 1'b0;
        gd = 1'b0;
        n = 0;
        while (n < budget && !gi && !gd) begin
            tick();
            n++;
            gi = i_mem_ready;
            gd = d_mem_ready;
        end
        if (gi) i_mem_read = 1'b0;
        if (gd) begin
            d_mem_read = 1'b0;
            d_mem_write = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] a;
        int n;
        bit gi, gd;
        tick();
        n_checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata,
             i_mem_ready, d_mem_ready, grant_d, conflict_cnt,
             i_mem_rdata, d_mem_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero (mem_addr=%h)",
                     mem_addr);
        end
        rst_n = 1'b1;
        auto_a = 1'b0;
        a = AW'($urandom);
        d_mem_addr = a;
        d_mem_read = 1'b1;
        tick();
        n_checks++;
        if (!(grant_d === 1'b1 && mem_read === 1'b1 && mem_addr === a)) begin
            n_fail++;
            $display("FAIL reset_pre_gnt_d: grant_d=%b mem_read=%b, need 1 1",
                     grant_d, mem_read);
        end
        mem_ready = 1'b1;
        mem_rdata = {DW{1'b1}};
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata,
             i_mem_ready, d_mem_ready, grant_d, conflict_cnt,
             i_mem_rdata, d_mem_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_async_abort: grant_d=%b mem_read=%b, need 0",
                     grant_d, mem_read);
        end
        mem_ready = 1'b0;
        d_mem_read = 1'b0;
        wait_a = 0;
        tick();
        rst_n = 1'b1;
        i_mem_read = 1'b1;
        i_mem_addr = 28'h0000010;
        tick();
        n_checks++;
        if (!(mem_read === 1'b1 && mem_write === 1'b0 &&
              mem_addr === 28'h0000010 && d_mem_ready === 1'b0)) begin
            n_fail++;
            $display("FAIL reset_new_i: rd=%b wr=%b addr=%h, need 1 0 0000010",
                     mem_read, mem_write, mem_addr);
        end
        auto_a = 1'b1;
        lat_a = 0;
        serve(10, n, gi, gd);
        n_checks++;
        if (!(gi && !gd)) begin
            n_fail++;
            $display("FAIL reset_new_i_done: gi=%b gd=%b, need 1 0", gi, gd);
        end
        repeat (2) tick();
    endtask

    task automatic test_i_read();
        logic [AW-1:0] a;
        int n, extra;
        bit gi, gd;
        lat_a = 3;
        rdata_a = {16{8'hA5}};
        a = AW'($urandom);
        i_mem_addr = a;
        i_mem_read = 1'b1;
        tick();
        n_checks++;
        if (!(mem_read === 1'b1 && mem_write === 1'b0 && mem_addr === a)) begin
            n_fail++;
            $display("FAIL i_read_strobe: rd=%b wr=%b addr=%h, need 1 0 %h",
                     mem_read, mem_write, mem_addr, a);
        end
        serve(20, n, gi, gd);
        n_checks++;
        if (!(gi && !gd && n + 1 == 5 && i_mem_rdata === rdata_a)) begin
            n_fail++;
            $display("FAIL i_read_done: gi=%b gd=%b lat=%0d data=%h, need 1 0 5 %h",
                     gi, gd, n + 1, i_mem_rdata, rdata_a);
        end
        extra = 0;
        repeat (4) begin
            tick();
            if (i_mem_ready || d_mem_ready) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL i_read_single_pulse: extra=%0d, need 0", extra);
        end
    endtask

    task automatic test_d_write();
        logic [DW-1:0] wd;
        int n;
        bit gi, gd;
        wd = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
        lat_a = int'($urandom_range(0, 3));
        d_mem_read = 1'b1;
        d_mem_write = 1'b1;
        d_mem_addr = 28'h0ABCDEF;
        d_mem_wdata = wd;
        tick();
        n_checks++;
        if (!(mem_write === 1'b1 && mem_read === 1'b0 && grant_d === 1'b1 &&
              mem_addr === 28'h0ABCDEF && mem_wdata === wd)) begin
            n_fail++;
            $display("FAIL d_write_strobe: wr=%b rd=%b addr=%h, need 1 0 0abcdef",
                     mem_write, mem_read, mem_addr);
        end
        serve(20, n, gi, gd);
        n_checks++;
        if (!(gd && !gi && n + 1 == lat_a + 2)) begin
            n_fail++;
            $display("FAIL d_write_done: gd=%b gi=%b lat=%0d, need 1 0 %0d",
                     gd, gi, n + 1, lat_a + 2);
        end
        tick();
        n_checks++;
        if (d_mem_ready !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL d_write_single_pulse: ready=%b wr=%b, need 0 0",
                     d_mem_ready, mem_write);
        end
        tick();
    endtask

    // Transaction-level model: winner by tie rule, latency L+2,
    // conflict grows by L+2 whenever the loser waits through a grant.
    task automatic test_round_robin();
        bit last_d_m, both, exp_d, gi, gd;
        int conf_m, n, lat, kind;
        logic [AW-1:0] ia, da;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_d_m = 1'b0;
        conf_m = 0;
        for (int r = 0; r < 12; r++) begin
            kind = (r < 2) ? 2 : int'($urandom_range(0, 2));
            lat = (r < 2) ? 0 : int'($urandom_range(0, 4));
            lat_a = lat;
            rdata_a = {$urandom, $urandom, $urandom, $urandom};
            ia = AW'($urandom);
            da = AW'($urandom);
            both = (kind == 2);
            exp_d = both ? !last_d_m : (kind == 1);
            i_mem_addr = ia;
            d_mem_addr = da;
            i_mem_read = (kind != 1);
            d_mem_read = (kind != 0);
            d_mem_write = (kind != 0) && ($urandom_range(0, 1) == 1);
            tick();
            n_checks++;
            if (grant_d !== exp_d || mem_addr !== (exp_d ? da : ia)) begin
                n_fail++;
                $display("FAIL rr_grant r%0d: grant_d=%b addr=%h, need %b %h",
                         r, grant_d, mem_addr, exp_d, exp_d ? da : ia);
            end
            serve(30, n, gi, gd);
            n_checks++;
            if (gd !== exp_d || gi !== !exp_d || n + 1 != lat + 2) begin
                n_fail++;
                $display("FAIL rr_first r%0d: gd=%b gi=%b lat=%0d, need %b %b %0d",
                         r, gd, gi, n + 1, exp_d, !exp_d, lat + 2);
            end
            last_d_m = exp_d;
            if (both) begin
                conf_m += lat + 2;
                serve(30, n, gi, gd);
                n_checks++;
                if (gd !== !exp_d || gi !== exp_d || n != lat + 3) begin
                    n_fail++;
                    $display("FAIL rr_second r%0d: gd=%b gi=%b n=%0d, need %b %b %0d",
                             r, gd, gi, n, !exp_d, exp_d, lat + 3);
                end
                last_d_m = !exp_d;
            end
            repeat (2) tick();
            n_checks++;
            if (conflict_cnt !== 16'(conf_m)) begin
                n_fail++;
                $display("FAIL rr_conflict r%0d: cnt=%0d, need %0d",
                         r, conflict_cnt, conf_m);
            end
        end
    endtask

    task automatic test_spurious();
        logic [DW-1:0] rd;
        auto_a = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = '1;
        tick();
        tick();
        n_checks++;
        if ({i_mem_ready, d_mem_ready, mem_read, mem_write, grant_d} !== 5'b0) begin
            n_fail++;
            $display("FAIL spurious_idle: rdy=%b%b strobes=%b%b, need 0",
                     i_mem_ready, d_mem_ready, mem_read, mem_write);
        end
        mem_ready = 1'b0;
        i_mem_addr = AW'($urandom);
        i_mem_read = 1'b1;
        tick();
        rd = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = 1'b1;
        mem_rdata = rd;
        tick();
        n_checks++;
        if (i_mem_ready !== 1'b1 || i_mem_rdata !== rd) begin
            n_fail++;
            $display("FAIL first_gnt_ready: rdy=%b data=%h, need 1 %h",
                     i_mem_ready, i_mem_rdata, rd);
        end
        i_mem_read = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({i_mem_ready, d_mem_ready, mem_read, grant_d} !== 4'b0 ||
            i_mem_rdata !== rd) begin
            n_fail++;
            $display("FAIL spurious_done: rdy=%b%b rd=%b data=%h, need 0 %h",
                     i_mem_ready, d_mem_ready, mem_read, i_mem_rdata, rd);
        end
        mem_ready = 1'b0;
        auto_a = 1'b1;
        wait_a = 0;
        tick();
    endtask

    task automatic test_d_priority();
        int pi, pd, wraps, k;
        logic [3:0] prev;
        lat_b = 0;
        rdata_b = '0;
        p_i_read = 1'b1;
        p_d_read = 1'b1;
        pi = 0;
        pd = 0;
        wraps = 0;
        prev = p_cnt;
        repeat (40) begin
            tick();
            if (p_i_ready) pi++;
            if (p_d_ready) pd++;
            if (p_cnt < prev) wraps++;
            prev = p_cnt;
        end
        n_checks++;
        if (pi != 0 || pd < 12) begin
            n_fail++;
            $display("FAIL dprio_wins: i_pulses=%0d d_pulses=%0d, need 0 >=12",
                     pi, pd);
        end
        n_checks++;
        if (p_cnt !== 4'hF || wraps != 0) begin
            n_fail++;
            $display("FAIL dprio_saturate: cnt=%0d wraps=%0d, need 15 0",
                     p_cnt, wraps);
        end
        p_d_read = 1'b0;
        k = 0;
        pi = 0;
        while (k < 12 && pi == 0) begin
            tick();
            k++;
            if (p_i_ready) pi++;
        end
        p_i_read = 1'b0;
        n_checks++;
        if (pi != 1 || p_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL dprio_i_after: i_pulses=%0d cnt=%0d, need 1 15",
                     pi, p_cnt);
        end
        repeat (2) tick();
    endtask

    initial begin
        i_mem_read = 1'b0;
        i_mem_addr = '0;
        d_mem_read = 1'b0;
        d_mem_write = 1'b0;
        d_mem_addr = '0;
        d_mem_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        p_i_read = 1'b0;
        p_i_addr = '0;
        p_d_read = 1'b0;
        p_d_write = 1'b0;
        p_d_addr = '0;
        p_d_wdata = '0;
        p_mem_rdata = '0;
        p_mem_ready = 1'b0;
        rdata_a = '0;
        rdata_b = '0;
        test_reset();
        test_i_read();
        test_d_write();
        test_round_robin();
        test_spurious();
        test_d_priority();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Arbitrates the single main-memory port between the I-cache refill path (feeds instruction fetch) and the D-cache refill/write-back path.
- One transaction outstanding at a time. Registered memory-side outputs. Per-requester one-cycle ready pulse.
- Sits between both caches and the external memory model. The caches' own miss stalls form the pipeline's memory_stall.

Parameters:
ADDR_W, 28, memory line address width (byte address [31:4])
DATA_W, 128, line width in bits
D_PRIORITY, 0, 1 = D-cache always wins ties; 0 = round-robin on ties
CNT_W, 16, width of saturating conflict counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
i_mem_read  input  1  I-cache line read request (level, held until i_mem_ready)
i_mem_addr  input  ADDR_W  I-cache line address
i_mem_rdata  output  DATA_W  line returned to I-cache, valid while i_mem_ready=1
i_mem_ready  output  1  one-cycle completion pulse to I-cache
d_mem_read  input  1  D-cache line read request (level)
d_mem_write  input  1  D-cache write-back request (level)
d_mem_addr  input  ADDR_W  D-cache line address
d_mem_wdata  input  DATA_W  D-cache write-back line
d_mem_rdata  output  DATA_W  line returned to D-cache, valid while d_mem_ready=1
d_mem_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  memory read strobe (registered)
mem_write  output  1  memory write strobe (registered)
mem_addr  output  ADDR_W  memory address (registered)
mem_wdata  output  DATA_W  memory write data (registered)
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
mem_ready  input  1  memory completion pulse
grant_d  output  1  1 while D owns the memory port (GNT_D or DONE after a D grant)
conflict_cnt  output  CNT_W  saturating count of cycles a request was pending while the other side held the port

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all outputs 0; last_served=I, so D wins the first tie under round-robin; conflict_cnt=0. Reset mid-transaction abandons it; no ready pulse is issued.
- States: IDLE, GNT_I, GNT_D, DONE.
- IDLE, I request only (i_mem_read): latch i_mem_addr. Next cycle mem_read=1, mem_write=0, mem_addr=latched address. Go to GNT_I.
- IDLE, D request only (d_mem_read|d_mem_write): latch address and wdata. If d_mem_write=1, issue a write only (mem_write=1, mem_read=0), even when d_mem_read is also 1. Otherwise issue a read. Go to GNT_D.
- IDLE, both requesting: D_PRIORITY=1 grants D. D_PRIORITY=0 grants the side not equal to last_served.
- GNT_x: mem_* held stable until mem_ready=1.
  - In the mem_ready cycle: capture mem_rdata into the response register, update last_served, go to DONE.
  - mem_read and mem_write drop to 0 at the same edge.
  - mem_ready seen in the first GNT cycle is legal.
- DONE (one cycle): x_mem_ready=1 and x_mem_rdata=captured line for the granted side only. The other side's ready stays 0; its rdata holds its last value. After a write, rdata = captured mem_rdata (don't-care for the cache). Next state is IDLE.
- Requester rule: the requester deasserts its request no later than the edge ending its ready cycle. IDLE does not re-check the last-served side.
- Latency: request first high in IDLE at cycle t → mem strobe at t+1 → mem_ready at t+1+L → x_mem_ready at t+2+L. Minimum t+2.
- Back-to-back: at least one IDLE cycle between transactions. A request arriving during GNT or DONE waits.
- conflict_cnt: +1 each cycle state is GNT_I/GNT_D/DONE and the non-owning side has a request high. Saturates at all-ones; no wrap.
- mem_ready while in IDLE or DONE is ignored.
- Request inputs are level-sensitive. A request dropped before grant is never issued.

Test Plan:
- Reset mid-GNT_D with mem_ready pending → all outputs 0 immediately; after release, a new i_mem_read=1 at addr 0x0000010 gives mem_read=1, mem_addr=0x0000010 one cycle later.
- I read alone, memory L=3, mem_rdata=128'hA5..A5 → i_mem_ready pulses exactly once, 5 cycles after the request, with i_mem_rdata=A5..A5; d_mem_ready stays 0.
- D write-back with d_mem_read=d_mem_write=1, addr 0x0ABCDEF, wdata=128'h1234.. → only mem_write=1 with that addr/data; d_mem_ready single pulse.
- Simultaneous I+D requests from reset, D_PRIORITY=0, L=0 → D served first, I second with ≥1 IDLE bubble; repeat both → D first again (last_served=I); conflict_cnt=2 after the first transaction (GNT_D+DONE).
- Same stimulus with D_PRIORITY=1 and D re-requesting continuously → D always wins the tie. With CNT_W=4 the counter holds at 15 once I has waited long enough (saturation, no wrap).
- Spurious mem_ready in IDLE → no ready pulse, no state change; mem_ready in the first GNT cycle → ready pulse on the next cycle.
